// File: rtl/alu_exec_stage.sv
// alu_exec_stage: registered RV64 integer ALU execute stage.
// A result is computed combinationally from the accepted bundle and lands in a
// two-entry output buffer (main drives out_*, skid absorbs one extra result).
// This lets the stage keep accepting while writeback stalls for one cycle.
// A saturating counter tracks how many results writeback has taken.
module alu_exec_stage #(
    parameter int XLEN  = 64,
    parameter int TAG_W = 5,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [XLEN-1:0]  in_a,
    input  logic [XLEN-1:0]  in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal,
    output logic [CNT_W-1:0] retired_cnt
);

    localparam int SHW = $clog2(XLEN);

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_SLT  = 4'd5,
        OP_SLTU = 4'd6,
        OP_SLL  = 4'd7,
        OP_SRL  = 4'd8,
        OP_SRA  = 4'd9
    } alu_op_e;

    logic [SHW-1:0]   shamt;
    logic [XLEN-1:0]  alu_result;
    logic             alu_illegal;
    logic             accept;
    logic             pop;

    logic             main_v;
    logic [XLEN-1:0]  main_result;
    logic [TAG_W-1:0] main_tag;
    logic             main_illegal;

    logic             skid_v;
    logic [XLEN-1:0]  skid_result;
    logic [TAG_W-1:0] skid_tag;
    logic             skid_illegal;

    assign shamt = in_b[SHW-1:0];

    // The skid entry being occupied is the only thing that stops acceptance,
    // so in_ready never depends combinationally on out_ready.
    assign in_ready = !skid_v && !flush;
    assign accept   = in_valid && in_ready;
    assign pop      = main_v && out_ready;

    assign out_valid   = main_v;
    assign out_result  = main_result;
    assign out_tag     = main_tag;
    assign out_illegal = main_illegal;

    // Combinational ALU; unknown op codes yield zero and raise the illegal flag.
    always_comb begin
        alu_result  = '0;
        alu_illegal = 1'b0;
        case (in_op)
            OP_ADD:  alu_result = in_a + in_b;
            OP_SUB:  alu_result = in_a - in_b;
            OP_AND:  alu_result = in_a & in_b;
            OP_OR:   alu_result = in_a | in_b;
            OP_XOR:  alu_result = in_a ^ in_b;
            OP_SLT:  alu_result = {{(XLEN-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
            OP_SLTU: alu_result = {{(XLEN-1){1'b0}}, (in_a < in_b)};
            OP_SLL:  alu_result = in_a << shamt;
            OP_SRL:  alu_result = in_a >> shamt;
            OP_SRA:  alu_result = $unsigned($signed(in_a) >>> shamt);
            default: alu_illegal = 1'b1;
        endcase
    end

    // Two-entry FIFO: main refills from skid first so ordering stays strict.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_v       <= 1'b0;
            main_result  <= '0;
            main_tag     <= '0;
            main_illegal <= 1'b0;
            skid_v       <= 1'b0;
            skid_result  <= '0;
            skid_tag     <= '0;
            skid_illegal <= 1'b0;
        end else if (flush) begin
            main_v <= 1'b0;
            skid_v <= 1'b0;
        end else if (!main_v || pop) begin
            if (skid_v) begin
                main_v       <= 1'b1;
                main_result  <= skid_result;
                main_tag     <= skid_tag;
                main_illegal <= skid_illegal;
                if (accept) begin
                    skid_result  <= alu_result;
                    skid_tag     <= in_tag;
                    skid_illegal <= alu_illegal;
                end else begin
                    skid_v <= 1'b0;
                end
            end else if (accept) begin
                main_v       <= 1'b1;
                main_result  <= alu_result;
                main_tag     <= in_tag;
                main_illegal <= alu_illegal;
            end else begin
                main_v <= 1'b0;
            end
        end else if (accept) begin
            skid_v       <= 1'b1;
            skid_result  <= alu_result;
            skid_tag     <= in_tag;
            skid_illegal <= alu_illegal;
        end
    end

    // Count writeback handshakes, holding at all-ones; flush does not touch it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_cnt <= '0;
        end else if (pop && (retired_cnt != {CNT_W{1'b1}})) begin
            retired_cnt <= retired_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_alu_exec_stage.sv
// tb_alu_exec_stage: randomized + directed scoreboard bench for alu_exec_stage.
// A second instance with a 2-bit counter shares all inputs to exercise saturation.
module tb_alu_exec_stage;

    typedef struct packed {
        logic [63:0] res;
        logic [4:0]  tag;
        logic        ill;
    } entry_t;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic [63:0] in_a;
    logic [63:0] in_b;
    logic [4:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_result;
    logic [4:0]  out_tag;
    logic        out_illegal;
    logic [31:0] retired_cnt;

    logic        in_ready2;
    logic        out_valid2;
    logic [63:0] out_result2;
    logic [4:0]  out_tag2;
    logic        out_illegal2;
    logic [1:0]  cnt2;

    entry_t sb[$];
    int     expRetired = 0;
    int     nVec = 0;
    int     nMis = 0;

    alu_exec_stage #(.XLEN(64), .TAG_W(5), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_tag(out_tag), .out_illegal(out_illegal), .retired_cnt(retired_cnt)
    );

    alu_exec_stage #(.XLEN(64), .TAG_W(5), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready2), .in_op(in_op),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .out_valid(out_valid2), .out_ready(out_ready), .out_result(out_result2),
        .out_tag(out_tag2), .out_illegal(out_illegal2), .retired_cnt(cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU written from the arithmetic rules, not the RTL structure.
    function automatic logic [63:0] refResult(input logic [3:0] op, input logic [63:0] a,
                                              input logic [63:0] b);
        int          sh;
        logic [63:0] r;
        sh = int'(b[5:0]);
        r  = 64'd0;
        case (op)
            4'd0: r = a + b;
            4'd1: r = a + (~b) + 64'd1;
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            4'd5: begin
                if (a[63] != b[63]) r = a[63] ? 64'd1 : 64'd0;
                else                r = (a < b) ? 64'd1 : 64'd0;
            end
            4'd6: r = (a < b) ? 64'd1 : 64'd0;
            4'd7: r = a << sh;
            4'd8: r = a >> sh;
            4'd9: begin
                r = a >> sh;
                if (a[63]) r = r | ~(64'hFFFF_FFFF_FFFF_FFFF >> sh);
            end
            default: r = 64'd0;
        endcase
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        nVec++;
        if (act !== exp) begin
            nMis++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Called one time unit after a rising edge; occupies exactly one cycle.
    task automatic applyStimulus(input logic v, input logic [3:0] op, input logic [63:0] a,
                                 input logic [63:0] b, input logic [4:0] tag,
                                 input logic ordy, input logic fl, output logic acc);
        logic   expRdy;
        entry_t e;
        in_valid  = v;
        in_op     = op;
        in_a      = a;
        in_b      = b;
        in_tag    = tag;
        out_ready = ordy;
        flush     = fl;
        #1;
        expRdy = (sb.size() < 2) && !fl;
        checkOutput("in_ready", {63'd0, in_ready}, {63'd0, expRdy});
        acc = v && expRdy;
        @(posedge clk);
        if (fl) begin
            sb.delete();
        end else if (acc) begin
            e.res = refResult(op, a, b);
            e.tag = tag;
            e.ill = (op > 4'd9);
            sb.push_back(e);
        end
        #1;
    endtask

    task automatic idle(input int n, input logic ordy);
        logic acc;
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 4'd0, 64'd0, 64'd0, 5'd0, ordy, 1'b0, acc);
    endtask

    task automatic issue(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                         input logic [4:0] tag, input logic ordy);
        logic acc;
        int   tries;
        acc   = 1'b0;
        tries = 0;
        while (!acc && tries < 20) begin
            applyStimulus(1'b1, op, a, b, tag, ordy, 1'b0, acc);
            tries++;
        end
        nVec++;
        if (!acc) begin
            nMis++;
            $display("[TB] FAIL accept_timeout: got none expected accept within 20 cycles");
        end
        in_valid = 1'b0;
    endtask

    task automatic checkResetOutputs();
        checkOutput("rst_out_valid", {63'd0, out_valid}, 64'd0);
        checkOutput("rst_out_result", out_result, 64'd0);
        checkOutput("rst_out_tag", {59'd0, out_tag}, 64'd0);
        checkOutput("rst_out_illegal", {63'd0, out_illegal}, 64'd0);
        checkOutput("rst_retired_cnt", {32'd0, retired_cnt}, 64'd0);
        checkOutput("rst_retired_cnt2", {62'd0, cnt2}, 64'd0);
    endtask

    // Asynchronous reset asserted between clock edges.
    task automatic doReset();
        in_valid = 1'b0;
        flush    = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checkResetOutputs();
        sb.delete();
        expRetired = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    function automatic logic [63:0] randOperand();
        case ($urandom_range(0, 5))
            0:       return 64'd0;
            1:       return 64'hFFFF_FFFF_FFFF_FFFF;
            2:       return 64'h8000_0000_0000_0000;
            3:       return 64'($urandom_range(0, 70));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // Monitor: checks the head of the scoreboard whenever it should be on out_*.
    initial begin
        logic mv;
        int   sat;
        entry_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                mv = (sb.size() > 0);
                checkOutput("out_valid", {63'd0, out_valid}, {63'd0, mv});
                if (mv) begin
                    e = sb[0];
                    checkOutput("out_result", out_result, e.res);
                    checkOutput("out_tag", {59'd0, out_tag}, {59'd0, e.tag});
                    checkOutput("out_illegal", {63'd0, out_illegal}, {63'd0, e.ill});
                end
                sat = (expRetired > 3) ? 3 : expRetired;
                checkOutput("retired_cnt", {32'd0, retired_cnt}, 64'(expRetired));
                checkOutput("retired_cnt_sat", {62'd0, cnt2}, 64'(sat));
                if (mv && out_ready) begin
                    void'(sb.pop_front());
                    expRetired++;
                end
            end
        end
    end

    initial begin
        logic       acc;
        logic [3:0] op;
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_op     = 4'd0;
        in_a      = 64'd0;
        in_b      = 64'd0;
        in_tag    = 5'd0;
        out_ready = 1'b0;
        #3;
        checkResetOutputs();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Signed compares, one-cycle latency with writeback always ready
        issue(4'd5, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 5'd1, 1'b1);
        issue(4'd5, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 5'd2, 1'b1);
        issue(4'd5, 64'd100, 64'd100, 5'd3, 1'b1);
        idle(2, 1'b1);

        // Unsigned compare and arithmetic shift
        issue(4'd6, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 5'd4, 1'b1);
        issue(4'd9, 64'h8000_0000_0000_0000, 64'd4, 5'd5, 1'b1);
        idle(2, 1'b1);

        // Backpressure: two fit, the third waits until writeback drains
        applyStimulus(1'b1, 4'd0, 64'd10, 64'd1, 5'd1, 1'b0, 1'b0, acc);
        applyStimulus(1'b1, 4'd0, 64'd20, 64'd2, 5'd2, 1'b0, 1'b0, acc);
        applyStimulus(1'b1, 4'd0, 64'd30, 64'd3, 5'd3, 1'b0, 1'b0, acc);
        issue(4'd0, 64'd30, 64'd3, 5'd3, 1'b1);
        idle(4, 1'b1);

        // Flush with both entries occupied
        applyStimulus(1'b1, 4'd0, 64'd7, 64'd7, 5'd8, 1'b0, 1'b0, acc);
        applyStimulus(1'b1, 4'd1, 64'd7, 64'd9, 5'd9, 1'b0, 1'b0, acc);
        applyStimulus(1'b0, 4'd0, 64'd0, 64'd0, 5'd0, 1'b0, 1'b1, acc);
        idle(2, 1'b1);

        // Illegal op code
        issue(4'd12, 64'h1234, 64'h5678, 5'd12, 1'b1);
        idle(2, 1'b1);

        // Async reset mid-stall, then counter saturation on the 2-bit instance
        applyStimulus(1'b1, 4'd3, 64'hF0, 64'h0F, 5'd20, 1'b0, 1'b0, acc);
        applyStimulus(1'b1, 4'd4, 64'hF0, 64'hFF, 5'd21, 1'b0, 1'b0, acc);
        doReset();
        for (int i = 0; i < 5; i++) issue(4'd0, 64'(i), 64'd1, 5'(i + 1), 1'b1);
        idle(2, 1'b1);

        // Randomized traffic with backpressure and occasional flush
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) == 0) op = 4'($urandom_range(10, 15));
            else                           op = 4'($urandom_range(0, 9));
            applyStimulus(($urandom_range(0, 3) != 0), op, randOperand(), randOperand(),
                          5'($urandom_range(0, 31)), ($urandom_range(0, 9) < 7),
                          ($urandom_range(0, 39) == 0), acc);
        end
        idle(4, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule
